// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  // Arbiter FSM: whether a read is outstanding and whose it is
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_EXT = 2'd2
  } state_t;

  // Owner of the read currently travelling through the RAM pipeline
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  // Latency counter width; holds MEM_LAT-1 for MEM_LAT up to 4
  localparam int LAT_W = 2;

endpackage

// File: rtl/dmem_resp_tracker.sv
// rtl/dmem_resp_tracker.sv - read-latency countdown and response-owner strobes
module dmem_resp_tracker
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_rd,
  input  logic issue_cpu,
  output logic resp_cpu,
  output logic resp_ext
);

  logic [LAT_W-1:0] lat_cnt;
  owner_t           owner;

  // Load the countdown on a read issue, count down, then release ownership after the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt <= '0;
      owner   <= OWN_NONE;
    end else if (issue_rd) begin
      lat_cnt <= LAT_W'(MEM_LAT - 1);
      owner   <= issue_cpu ? OWN_CPU : OWN_EXT;
    end else if (lat_cnt != '0) begin
      lat_cnt <= lat_cnt - 1'b1;
    end else if (owner != OWN_NONE) begin
      owner <= OWN_NONE;
    end
  end

  // Response cycle: the outstanding read has reached the end of its latency
  always_comb begin
    resp_cpu = (owner == OWN_CPU) && (lat_cnt == '0);
    resp_ext = (owner == OWN_EXT) && (lat_cnt == '0);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data-memory port between the CPU and an external master
// Optional statistics outputs are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_grants,
  output logic [15:0]       stat_ext_grants,
  output logic [15:0]       stat_stall_cycles
`endif
);

  state_t            state;
  state_t            state_next;
  logic [3:0]        starve_cnt;
  logic              resp_cpu;
  logic              resp_ext;
  logic              can_issue;
  logic              cpu_elig;
  logic              ext_starved;
  logic              cpu_grant;
  logic              ext_grant;
  logic              issue_rd;
  logic [DATA_W-1:0] rdata_q;

  dmem_resp_tracker #(
    .MEM_LAT(MEM_LAT)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .issue_rd (issue_rd),
    .issue_cpu(cpu_grant),
    .resp_cpu (resp_cpu),
    .resp_ext (resp_ext)
  );

  // Arbitration: issue from IDLE or in a response cycle; CPU wins unless the external master is starved.
  // In a CPU response cycle the held cpu_req belongs to the load being answered, so it is not re-issued.
  always_comb begin
    can_issue   = !rst && ((state == IDLE) || resp_cpu || resp_ext);
    cpu_elig    = cpu_req && !resp_cpu;
    ext_starved = ext_valid && (starve_cnt == 4'(STARVE_MAX));
    cpu_grant   = can_issue && cpu_elig && !ext_starved;
    ext_grant   = can_issue && ext_valid && !cpu_grant;
    issue_rd    = (cpu_grant && !cpu_we) || (ext_grant && !ext_we);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: a read issue enters RD_*, a response without a new read returns to IDLE
  always_comb begin
    state_next = state;
    if (cpu_grant && !cpu_we)      state_next = RD_CPU;
    else if (ext_grant && !ext_we) state_next = RD_EXT;
    else if (resp_cpu || resp_ext) state_next = IDLE;
  end

  // FSM outputs: RAM strobe from the winner, handshakes, stall and read-data return
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_grant) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
    ext_ready  = ext_grant;
    cpu_stall  = !rst && cpu_req && !((cpu_grant && cpu_we) || resp_cpu);
    cpu_rdata  = resp_cpu ? mem_rdata : rdata_q;
    ext_rvalid = resp_ext;
    ext_rdata  = resp_ext ? mem_rdata : '0;
  end

  // Hold the last delivered CPU load value between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rdata_q <= '0;
    else if (resp_cpu) rdata_q <= mem_rdata;
  end

  // Starvation guard: count CPU wins while the external master waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          starve_cnt <= '0;
    else if (ext_grant || !ext_valid) starve_cnt <= '0;
    else if (cpu_grant && (starve_cnt != 4'(STARVE_MAX)))
      starve_cnt <= starve_cnt + 4'd1;
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cpu_grants   <= '0;
      stat_ext_grants   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (cpu_grant && (stat_cpu_grants != 16'hFFFF))
        stat_cpu_grants <= stat_cpu_grants + 16'd1;
      if (ext_grant && (stat_ext_grants != 16'hFFFF))
        stat_ext_grants <= stat_ext_grants + 16'd1;
      if (cpu_stall && (stat_stall_cycles != 16'hFFFF))
        stat_stall_cycles <= stat_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (MEM_LAT=1, STARVE_MAX=4)
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_valid, ext_ready, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_cpu_grants, stat_ext_grants, stat_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram   [0:255];
  logic [31:0] model [0:255];
  logic [31:0] exp_cpu_q[$];
  logic [31:0] exp_ext_q[$];
  logic [31:0] last_cpu;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_cpu_grants(stat_cpu_grants), .stat_ext_grants(stat_ext_grants),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_valid = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  // Wait at negedges for the CPU load response; w = cycles after the first sampled cycle
  task automatic wait_cpu_resp(output int w);
    for (w = 0; w < 8; w++) begin
      @(negedge clk);
      if (cpu_stall === 1'b0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ext_resp(output int w);
    for (w = 0; w < 8; w++) begin
      @(negedge clk);
      if (ext_rvalid === 1'b1) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] exp_c;
    rst = 1; idle_inputs();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h5; ext_valid = 1; ext_addr = 32'h9;
    @(negedge clk);
    n_checks++;
    if ({cpu_rdata, cpu_stall, ext_ready, ext_rvalid, ext_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== '0 ||
        dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_outputs: mem_en=%b cpu_stall=%b ext_ready=%b state=%0d required all 0/IDLE",
               mem_en, cpu_stall, ext_ready, dut.state);
    end
    idle_inputs();
    step(); step();
    rst = 0;
    step();
    exp_c = 32'h0;
    @(negedge clk);
    n_checks++;
    if (cpu_rdata !== exp_c || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: cpu_rdata=%h mem_en=%b required %h 0", cpu_rdata, mem_en, exp_c);
    end
  endtask

  task automatic test_cpu_store;
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12; cpu_wdata = 16; model[12] = 16;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_stall} !== {1'b1, 1'b1, 32'd12, 32'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL cpu_store: en=%b we=%b addr=%0d wdata=%0d stall=%b required 1 1 12 16 0",
               mem_en, mem_we, mem_addr, mem_wdata, cpu_stall);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_cpu_load;
    int w;
    logic [31:0] exp_d;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12; cpu_wdata = 4; model[12] = 4;
    step();
    cpu_we = 0; cpu_wdata = 0;
    exp_cpu_q.push_back(model[12]);
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'd12}) begin
      n_fail++;
      $display("FAIL cpu_load_issue: stall=%b en=%b we=%b addr=%0d required 1 1 0 12",
               cpu_stall, mem_en, mem_we, mem_addr);
    end
    step();
    wait_cpu_resp(w);
    exp_d = exp_cpu_q.pop_front();
    last_cpu = exp_d;
    n_checks++;
    if (w !== 0 || cpu_rdata !== exp_d) begin
      n_fail++;
      $display("FAIL cpu_load_resp: extra_wait=%0d rdata=%h required 0 %h", w, cpu_rdata, exp_d);
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (cpu_rdata !== last_cpu || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_rdata_hold: rdata=%h stall=%b required %h 0", cpu_rdata, cpu_stall, last_cpu);
    end
    step();
  endtask

  task automatic test_contention;
    int w;
    logic [31:0] exp_d;
    ext_valid = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'hAB; model[8'h40] = 32'hAB;
    @(negedge clk);
    n_checks++;
    if (ext_ready !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_write: ready=%b addr=%h we=%b required 1 40 1", ext_ready, mem_addr, mem_we);
    end
    step();
    idle_inputs();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12; cpu_wdata = 32'h77; model[12] = 32'h77;
    ext_valid = 1; ext_we = 0; ext_addr = 32'h40;
    exp_ext_q.push_back(model[8'h40]);
    @(negedge clk);
    n_checks++;
    if ({mem_we, mem_addr, ext_ready, cpu_stall} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL contention_cpu_wins: we=%b addr=%h ready=%b stall=%b required 1 c 0 0",
               mem_we, mem_addr, ext_ready, cpu_stall);
    end
    step();
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    n_checks++;
    if ({ext_ready, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h40}) begin
      n_fail++;
      $display("FAIL contention_ext_next: ready=%b en=%b we=%b addr=%h required 1 1 0 40",
               ext_ready, mem_en, mem_we, mem_addr);
    end
    step();
    idle_inputs();
    wait_ext_resp(w);
    exp_d = exp_ext_q.pop_front();
    n_checks++;
    if (w !== 0 || ext_rvalid !== 1'b1 || ext_rdata !== exp_d) begin
      n_fail++;
      $display("FAIL ext_read_resp: extra_wait=%0d rvalid=%b rdata=%h required 0 1 %h",
               w, ext_rvalid, ext_rdata, exp_d);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (ext_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_rvalid_pulse: rvalid=%b required 0", ext_rvalid);
    end
    step();
  endtask

  task automatic test_starvation;
    ext_valid = 1; ext_we = 1; ext_addr = 32'h50; ext_wdata = 32'h55;
    cpu_req = 1; cpu_we = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 20 + i; cpu_wdata = 100 + i; model[20 + i] = 100 + i;
      @(negedge clk);
      n_checks++;
      if (mem_addr !== 32'(20 + i) || ext_ready !== 1'b0 || cpu_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL starve_cpu_grant%0d: addr=%0d ready=%b stall=%b required %0d 0 0",
                 i, mem_addr, ext_ready, cpu_stall, 20 + i);
      end
      step();
    end
    cpu_addr = 24; cpu_wdata = 104; model[24] = 104; model[8'h50] = 32'h55;
    @(negedge clk);
    n_checks++;
    if ({ext_ready, cpu_stall, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h50, 32'h55}) begin
      n_fail++;
      $display("FAIL starve_ext_grant: ready=%b stall=%b addr=%h wdata=%h required 1 1 50 55",
               ext_ready, cpu_stall, mem_addr, mem_wdata);
    end
    step();
    ext_valid = 0; ext_we = 0;
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, mem_addr, ext_ready} !== {1'b0, 32'd24, 1'b0} || dut.starve_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL starve_cpu_again: stall=%b addr=%0d ready=%b starve_cnt=%0d required 0 24 0 0",
               cpu_stall, mem_addr, ext_ready, dut.starve_cnt);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_inflight;
    int rv_seen;
    int w;
    logic [31:0] exp_d;
    ext_valid = 1; ext_we = 0; ext_addr = 32'h40;
    @(negedge clk);
    n_checks++;
    if (ext_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_issue: ready=%b required 1", ext_ready);
    end
    #2;
    rst = 1;
    ext_valid = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12;
    #1;
    n_checks++;
    if ({cpu_rdata, cpu_stall, ext_ready, ext_rvalid, ext_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL inflight_rst_outputs: en=%b stall=%b rvalid=%b required 0 0 0", mem_en, cpu_stall, ext_rvalid);
    end
    rv_seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ext_rvalid !== 1'b0 || mem_en !== 1'b0 || cpu_stall !== 1'b0) rv_seen++;
    end
    n_checks++;
    if (rv_seen !== 0 || dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL inflight_rst_hold: bad_cycles=%0d state=%0d required 0 IDLE", rv_seen, dut.state);
    end
    step();
    rst = 0;
    exp_cpu_q.push_back(model[12]);
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, mem_addr, cpu_stall, ext_rvalid} !== {1'b1, 1'b0, 32'd12, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_grant: en=%b we=%b addr=%0d stall=%b rvalid=%b required 1 0 12 1 0",
               mem_en, mem_we, mem_addr, cpu_stall, ext_rvalid);
    end
    step();
    wait_cpu_resp(w);
    exp_d = exp_cpu_q.pop_front();
    n_checks++;
    if (w !== 0 || cpu_rdata !== exp_d || ext_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_load: extra_wait=%0d rdata=%h rvalid=%b required 0 %h 0",
               w, cpu_rdata, ext_rvalid, exp_d);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back;
    int w;
    logic [31:0] exp_d;
    ext_valid = 1; ext_we = 0; ext_addr = 32'h50;
    exp_ext_q.push_back(model[8'h50]);
    step();
    idle_inputs();
    cpu_req = 1; cpu_we = 0; cpu_addr = 22;
    exp_cpu_q.push_back(model[22]);
    @(negedge clk);
    exp_d = exp_ext_q.pop_front();
    n_checks++;
    if ({ext_rvalid, ext_rdata, mem_en, mem_we, mem_addr} !== {1'b1, exp_d, 1'b1, 1'b0, 32'd22}) begin
      n_fail++;
      $display("FAIL b2b_overlap: rvalid=%b rdata=%h en=%b addr=%0d required 1 %h 1 22",
               ext_rvalid, ext_rdata, mem_en, mem_addr, exp_d);
    end
    step();
    wait_cpu_resp(w);
    exp_d = exp_cpu_q.pop_front();
    n_checks++;
    if (w !== 0 || cpu_rdata !== exp_d) begin
      n_fail++;
      $display("FAIL b2b_cpu_resp: extra_wait=%0d rdata=%h required 0 %h", w, cpu_rdata, exp_d);
    end
    step();
    idle_inputs();
    step();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats;
    int w;
    logic [31:0] exp_d;
    rst = 1; idle_inputs();
    step();
    rst = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 20 + i;
      exp_cpu_q.push_back(model[20 + i]);
      step();
      wait_cpu_resp(w);
      exp_d = exp_cpu_q.pop_front();
      n_checks++;
      if (w !== 0 || cpu_rdata !== exp_d) begin
        n_fail++;
        $display("FAIL stats_load%0d: extra_wait=%0d rdata=%h required 0 %h", i, w, cpu_rdata, exp_d);
      end
      step();
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      ext_valid = 1; ext_we = 1; ext_addr = 60 + i; ext_wdata = i; model[60 + i] = i;
      step();
    end
    idle_inputs();
    step();
    @(negedge clk);
    n_checks++;
    if ({stat_cpu_grants, stat_ext_grants, stat_stall_cycles} !== {16'd3, 16'd2, 16'd3}) begin
      n_fail++;
      $display("FAIL stats_counts: cpu=%0d ext=%0d stall=%0d required 3 2 3",
               stat_cpu_grants, stat_ext_grants, stat_stall_cycles);
    end
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) model[i] = '0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    last_cpu = '0;
    step();
    test_reset();
    test_cpu_store();
    test_cpu_load();
    test_contention();
    test_starvation();
    test_reset_inflight();
    test_back_to_back();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    if (exp_cpu_q.size() != 0 || exp_ext_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: cpu_left=%0d ext_left=%0d required 0 0",
               exp_cpu_q.size(), exp_ext_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
